// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding, frame geometry and the parity
// rule. The RX engine uses the same parity function, so both ends agree.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  localparam int FRAME_W  = 11;  // start + 8 data + parity + stop
  localparam int BASE_LEN = 9;   // start + 7 data + stop

  // Even-parity sense over the active data bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic       bit8_en,
                                      input logic       odd_en);
    logic p;
    p = (^data[6:0]) ^ (bit8_en & data[7]);
    return odd_en ? ~p : p;
  endfunction

  // Frame bits LSB first; positions past the stop bit stay at the idle level.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data,
                                                     input logic       bit8_en,
                                                     input logic       parity_en,
                                                     input logic       odd_en);
    logic [FRAME_W-1:0] f;
    logic               par;
    par    = parity_bit(data, bit8_en, odd_en);
    f      = '1;
    f[0]   = 1'b0;
    f[7:1] = data[6:0];
    if (bit8_en) begin
      f[8] = data[7];
      if (parity_en) f[9] = par;
    end else if (parity_en) begin
      f[8] = par;
    end
    return f;
  endfunction

  // Number of bit times in a frame: 9, 10 or 11.
  function automatic logic [3:0] frame_len(input logic bit8_en,
                                           input logic parity_en);
    return 4'(BASE_LEN) + {3'b000, bit8_en} + {3'b000, parity_en};
  endfunction

endpackage

// File: rtl/tx_shiftreg_piso.sv
// 11-bit parallel-in/serial-out shift register. Shifts right and fills with
// 1 so the line naturally returns to idle once the frame has drained.
module tx_shiftreg_piso
  import uart_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               ld,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame,
  output logic               sout
);

  logic [FRAME_W-1:0] sr_q;
  logic [FRAME_W-1:0] sr_d;

  // Next shift-register value: load wins over shift.
  always_comb begin
    // NOTE: default assignment first so every path drives sr_d and no latch is inferred.
    sr_d = sr_q;
    if (ld) begin
      sr_d = frame;
    end else if (shift) begin
      sr_d = {1'b1, sr_q[FRAME_W-1:1]};
    end
  end

  // Register with asynchronous reset to the idle (all-ones) pattern.
  always_ff @(posedge Clk or negedge Rst) begin
    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    if (!Rst) sr_q <= '1;
    else      sr_q <= sr_d;
  end

  assign sout = sr_q[0];

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: double-buffered byte holding register feeding a
// PISO frame shifter, with a bit-time counter and a two-state FSM.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_W = 19
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [DIV_W-1:0] k,
  input  logic             load,
  input  logic [7:0]       data_in,
  input  logic             bit8_en,
  input  logic             parity_en,
  input  logic             odd_en,
  output logic             Tx,
  output logic             Tx_rdy,
  output logic             Tx_busy
);

  tx_state_e          state_q, state_d;
  logic               full_q, full_d;
  logic [7:0]         hold_q, hold_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;     // cycles elapsed in the current bit
  logic [DIV_W-1:0]   kp_q, kp_d;       // bit time latched for this frame
  logic [3:0]         idx_q, idx_d;     // index of the bit on the line
  logic [3:0]         len_q, len_d;     // frame length latched for this frame

  logic               bit_end;
  logic               last_bit;
  logic               frame_end;
  logic               transfer;
  logic               shift;
  logic               accept;
  logic [FRAME_W-1:0] frame;

  // Frame-control decodes shared by the FSM, the holding register and PISO.
  always_comb begin
    bit_end   = (cnt_q == (kp_q - DIV_W'(1)));
    last_bit  = (idx_q == (len_q - 4'd1));
    frame_end = (state_q == ST_SEND) && bit_end && last_bit;
    transfer  = full_q && ((state_q == ST_IDLE) || frame_end);
    shift     = (state_q == ST_SEND) && bit_end && !last_bit;
    accept    = load && !full_q;
    frame     = build_frame(hold_q, bit8_en, parity_en, odd_en);
  end

  // Holding register: accept a byte only when empty; drain on transfer.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (accept) begin
      hold_d = data_in;
      full_d = 1'b1;
    end else if (transfer) begin
      full_d = 1'b0;
    end
  end

  // FSM next state plus bit counter, bit index and per-frame config latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    kp_d    = kp_q;
    len_d   = len_q;

    if (transfer) begin
      kp_d  = (k == '0) ? DIV_W'(1) : k;
      len_d = frame_len(bit8_en, parity_en);
    end

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!last_bit) begin
            idx_d = idx_q + 4'd1;
          end else if (transfer) begin
            idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers, all asynchronously reset to the idle configuration.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      full_q  <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
      kp_q    <= DIV_W'(1);
      idx_q   <= '0;
      len_q   <= 4'(BASE_LEN);
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      kp_q    <= kp_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

  // The PISO output is a flop; it holds the stop bit (1) whenever the FSM
  // is idle and resets to 1, so it drives the line directly.
  tx_shiftreg_piso u_piso (
    .Clk   (Clk),
    .Rst   (Rst),
    .ld    (transfer),
    .shift (shift),
    .frame (frame),
    .sout  (Tx)
  );

  assign Tx_rdy  = ~full_q;
  assign Tx_busy = (state_q == ST_SEND);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a waveform-queue line model checked
// every cycle, plus directed frames with hand-computed bit strings.
module tb_uart_tx_engine;

  logic        Clk;
  logic        Rst;
  logic [18:0] k;
  logic        load;
  logic [7:0]  data_in;
  logic        bit8_en;
  logic        parity_en;
  logic        odd_en;
  logic        Tx;
  logic        Tx_rdy;
  logic        Tx_busy;

  int tests = 0;
  int fails = 0;

  uart_tx_engine #(.DIV_W(19)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .k         (k),
    .load      (load),
    .data_in   (data_in),
    .bit8_en   (bit8_en),
    .parity_en (parity_en),
    .odd_en    (odd_en),
    .Tx        (Tx),
    .Tx_rdy    (Tx_rdy),
    .Tx_busy   (Tx_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Line model: the upcoming Tx level of every cycle of the current frame.
  bit         wave[$];
  bit         m_full;
  logic [7:0] m_hold;
  int         busy_cycles = 0;
  int         busy_falls  = 0;
  bit         prev_busy   = 1'b0;

  // Build the expected per-cycle line levels of one frame from the rules.
  task automatic push_frame(input logic [7:0] d, input bit b8, input bit pe,
                            input bit oe, input int kk);
    bit bits[$];
    bit par;
    int kp;
    kp  = (kk == 0) ? 1 : kk;
    par = (($countones(d[6:0]) + ((b8 && d[7]) ? 1 : 0)) % 2 == 1);
    if (oe) par = !par;
    bits.push_back(1'b0);
    for (int i = 0; i < 7; i++) bits.push_back(d[i]);
    if (b8) bits.push_back(d[7]);
    if (pe) bits.push_back(par);
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < kp; c++) wave.push_back(bits[i]);
  endtask

  // Posedge: advance the model. Negedge: compare DUT against it.
  always @(posedge Clk or negedge Clk) begin
    bit full_pre;
    bit exp_tx;
    if (Clk) begin
      if (Rst) begin
        full_pre = m_full;
        if (wave.size() > 0) void'(wave.pop_front());
        if (full_pre && wave.size() == 0) begin
          push_frame(m_hold, bit8_en, parity_en, odd_en, int'(k));
          m_full = 1'b0;
        end
        if (load && !full_pre) begin
          m_hold = data_in;
          m_full = 1'b1;
        end
      end
    end else begin
      if (!Rst) begin
        wave.delete();
        m_full = 1'b0;
        m_hold = 8'h00;
      end
      exp_tx = (wave.size() > 0) ? wave[0] : 1'b1;
      check("tx_cycle",   32'(Tx),      32'(exp_tx));
      check("busy_cycle", 32'(Tx_busy), 32'(wave.size() > 0));
      check("rdy_cycle",  32'(Tx_rdy),  32'(!m_full));
      if (Tx_busy === 1'b1) busy_cycles++;
      if (prev_busy && Tx_busy !== 1'b1) busy_falls++;
      prev_busy = (Tx_busy === 1'b1);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Send one frame and check it against a hand-written bit string.
  task automatic do_frame(input string name, input int kin, input int kcyc,
                          input bit b8, input bit pe, input bit oe,
                          input logic [7:0] d, input string exp_bits);
    int b0;
    bit ok;
    k = 19'(kin); bit8_en = b8; parity_en = pe; odd_en = oe;
    data_in = d; load = 1'b1;
    tick();
    load = 1'b0;
    check({name, "_rdy_low"}, 32'(Tx_rdy), 32'd0);
    check({name, "_pre_start"}, 32'(Tx), 32'd1);
    b0 = busy_cycles;
    tick();
    check({name, "_rdy_back"}, 32'(Tx_rdy), 32'd1);
    // Config changes mid-frame must not disturb the frame in flight.
    k = 19'd7; bit8_en = ~b8; parity_en = ~pe; odd_en = ~oe;
    for (int i = 0; i < exp_bits.len(); i++) begin
      ok = 1'b1;
      for (int c = 0; c < kcyc; c++) begin
        if (Tx !== ((exp_bits[i] == "1") ? 1'b1 : 1'b0)) ok = 1'b0;
        tick();
      end
      check($sformatf("%s_bit%0d", name, i), 32'(ok), 32'd1);
    end
    check({name, "_idle_after"}, 32'(Tx_busy), 32'd0);
    check({name, "_frame_cycles"}, 32'(busy_cycles - b0), 32'(exp_bits.len() * kcyc));
  endtask

  initial begin
    int  b0, f0, waited;
    bit  got;
    Rst = 1'b0; load = 1'b0; data_in = 8'h5A; k = 19'd4;
    bit8_en = 1'b1; parity_en = 1'b0; odd_en = 1'b0;

    // Reset held for 3 cycles while load toggles.
    for (int i = 0; i < 3; i++) begin
      load = ~load;
      tick();
      check("rst_tx",   32'(Tx),      32'd1);
      check("rst_rdy",  32'(Tx_rdy),  32'd1);
      check("rst_busy", 32'(Tx_busy), 32'd0);
    end
    load = 1'b0;
    Rst  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_no_frame", 32'(busy_cycles), 32'd0);
    check("post_rst_tx", 32'(Tx), 32'd1);

    do_frame("8n1_a5",  4, 4, 1'b1, 1'b0, 1'b0, 8'hA5, "0101001011");
    do_frame("7e1_d5",  3, 3, 1'b0, 1'b1, 1'b0, 8'hD5, "0101010101");
    do_frame("7o1_d5",  3, 3, 1'b0, 1'b1, 1'b1, 8'hD5, "0101010111");
    do_frame("8o1_ff",  1, 1, 1'b1, 1'b1, 1'b1, 8'hFF, "01111111111");
    do_frame("k0_3c",   0, 1, 1'b1, 1'b0, 1'b0, 8'h3C, "0001111001");
    tick();

    // Back-to-back frames and a rejected write.
    k = 19'd2; bit8_en = 1'b1; parity_en = 1'b0; odd_en = 1'b0;
    b0 = busy_cycles; f0 = busy_falls;
    data_in = 8'h01; load = 1'b1;
    tick();
    load = 1'b0;
    got = 1'b0; waited = 0;
    while (!got && waited < 20) begin
      tick();
      waited++;
      if (Tx_rdy === 1'b1) got = 1'b1;
    end
    check("b2b_rdy_wait", 32'(got), 32'd1);
    data_in = 8'h80; load = 1'b1;
    tick();
    check("b2b_rdy_full", 32'(Tx_rdy), 32'd0);
    data_in = 8'h3C;
    tick();
    load = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("b2b_busy_cycles", 32'(busy_cycles - b0), 32'd40);
    check("b2b_one_gap",     32'(busy_falls - f0),  32'd1);
    check("b2b_idle",        32'(Tx), 32'd1);

    // Reset mid-frame discards the frame and the queued byte.
    k = 19'd5;
    data_in = 8'h00; load = 1'b1;
    tick();
    data_in = 8'h55;
    tick();
    tick();
    load = 1'b0;
    check("rmf_queued", 32'(Tx_rdy), 32'd0);
    for (int i = 0; i < 19; i++) tick();
    check("rmf_data_bit", 32'(Tx), 32'd0);
    Rst = 1'b0;
    #1;
    check("rmf_tx",   32'(Tx),      32'd1);
    check("rmf_rdy",  32'(Tx_rdy),  32'd1);
    check("rmf_busy", 32'(Tx_busy), 32'd0);
    tick();
    tick();
    Rst = 1'b1;
    b0 = busy_cycles;
    for (int i = 0; i < 30; i++) tick();
    check("rmf_stays_idle", 32'(busy_cycles - b0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
